// File: rtl/cw_encode_ctrl_pkg.sv
// Shared widths, default best_d latency, FSM encoding and helpers for the
// constant-weight encoder sequencer.
package cw_pkg;

    localparam int unsigned N_W        = 11;
    localparam int unsigned T_W        = 6;
    localparam int unsigned D_W        = 10;
    localparam int unsigned U_W        = 4;
    localparam int unsigned BD_LAT_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT,
        ST_RD_FLAG,
        ST_RD_IDX,
        ST_EMIT,
        ST_FLUSH,
        ST_DONE
    } cw_state_e;

    // Limit a decoded index to the remaining slack n-t.
    function automatic logic [N_W-1:0] clamp_idx(input logic [N_W-1:0] raw,
                                                 input logic [N_W-1:0] lim);
        return (raw > lim) ? lim : raw;
    endfunction

endpackage

// File: rtl/cw_encode_ctrl_if.sv
// Message-bit and support-position streams of the encoder sequencer.
// master: the sequencer (consumes bits, produces positions).
// slave:  the surrounding bit source / position sink.
interface cw_encode_ctrl_if;
    import cw_pkg::*;

    logic           bit_in;
    logic           bit_valid;
    logic           bit_ready;
    logic [N_W-1:0] pos_out;
    logic           pos_valid;
    logic           pos_ready;

    modport master (
        input  bit_in,
        input  bit_valid,
        output bit_ready,
        output pos_out,
        output pos_valid,
        input  pos_ready
    );

    modport slave (
        output bit_in,
        output bit_valid,
        input  bit_ready,
        input  pos_out,
        input  pos_valid,
        output pos_ready
    );

endinterface

// File: rtl/cw_encode_ctrl_bit_fetch.sv
// Bit collector for the sequencer: takes a single flag bit, or an index of
// len_i bits shifted in MSB first, from the valid/ready message stream.
module cw_bit_fetch
    import cw_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           flag_en_i,
    input  logic           idx_en_i,
    input  logic           load_i,
    input  logic [U_W-1:0] len_i,
    input  logic           bit_i,
    input  logic           bit_valid_i,
    output logic           bit_ready_o,
    output logic           fire_o,
    output logic           last_o,
    output logic           empty_o,
    output logic [D_W-1:0] value_o
);

    logic [U_W-1:0] k_q, k_d;
    logic [D_W-1:0] acc_q, acc_d;

    // Handshake and status decode; value_o already includes the bit on the bus.
    always_comb begin
        bit_ready_o = flag_en_i | (idx_en_i & (k_q != '0));
        fire_o      = bit_ready_o & bit_valid_i;
        empty_o     = idx_en_i & (k_q == '0);
        last_o      = idx_en_i & fire_o & (k_q == U_W'(1));
        value_o     = (acc_q << 1) | D_W'(bit_i);
    end

    // Remaining-bit counter and shift accumulator update.
    always_comb begin
        k_d   = k_q;
        acc_d = acc_q;
        if (load_i) begin
            k_d   = len_i;
            acc_d = '0;
        end else if (idx_en_i && fire_o) begin
            k_d   = k_q - U_W'(1);
            acc_d = value_o;
        end
    end

    // Counter/accumulator registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            acc_q <= '0;
        end else begin
            k_q   <= k_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cw_encode_ctrl.sv
// Constant-weight encoder sequencer: drives (n,t) to best_d, waits out its
// latency, consumes message bits and emits the t support positions in
// ascending order.
module cw_encode_ctrl
    import cw_pkg::*;
#(
    parameter int unsigned BD_LAT = BD_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_W-1:0]         n_init,
    input  logic [T_W-1:0]         t_init,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    cw_encode_ctrl_if.master       strm,
    output logic [N_W-1:0]         bd_n,
    output logic [T_W-1:0]         bd_t,
    input  logic [D_W-1:0]         bd_d,
    input  logic [U_W-1:0]         bd_u,
    output logic [15:0]            bits_used
);

    localparam int unsigned WAIT_W = $clog2(BD_LAT + 1) + 1;

    cw_state_e       state_q, state_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [T_W-1:0]  t_q, t_d;
    logic [N_W-1:0]  pos_q, pos_d;
    logic [D_W-1:0]  idx_q, idx_d;
    logic [D_W-1:0]  d_q, d_d;
    logic [U_W-1:0]  u_q, u_d;
    logic            err_q, err_d;
    logic [15:0]     bits_q, bits_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [N_W-1:0]  bd_n_q, bd_n_d;
    logic [T_W-1:0]  bd_t_q, bd_t_d;

    logic            fetch_load;
    logic            fetch_ready;
    logic            fetch_fire;
    logic            fetch_last;
    logic            fetch_empty;
    logic [D_W-1:0]  fetch_value;
    logic [N_W-1:0]  slack;

    cw_bit_fetch u_fetch (
        .clk         (clk),
        .rst         (rst),
        .flag_en_i   (state_q == ST_RD_FLAG),
        .idx_en_i    (state_q == ST_RD_IDX),
        .load_i      (fetch_load),
        .len_i       (u_q),
        .bit_i       (strm.bit_in),
        .bit_valid_i (strm.bit_valid),
        .bit_ready_o (fetch_ready),
        .fire_o      (fetch_fire),
        .last_o      (fetch_last),
        .empty_o     (fetch_empty),
        .value_o     (fetch_value)
    );

    // Moore outputs decoded from state and registers.
    always_comb begin
        slack          = n_q - N_W'(t_q);
        strm.bit_ready = fetch_ready;
        strm.pos_valid = (state_q == ST_EMIT) || (state_q == ST_FLUSH);
        strm.pos_out   = '0;
        if (state_q == ST_EMIT) begin
            strm.pos_out = pos_q + N_W'(idx_q);
        end else if (state_q == ST_FLUSH) begin
            strm.pos_out = pos_q;
        end
        busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done      = (state_q == ST_DONE);
        err       = err_q;
        bd_n      = bd_n_q;
        bd_t      = bd_t_q;
        bits_used = bits_q;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        t_d        = t_q;
        pos_d      = pos_q;
        idx_d      = idx_q;
        d_d        = d_q;
        u_d        = u_q;
        err_d      = err_q;
        bits_d     = bits_q;
        wait_d     = wait_q;
        bd_n_d     = bd_n_q;
        bd_t_d     = bd_t_q;
        fetch_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d     = n_init;
                    t_d     = t_init;
                    pos_d   = '0;
                    err_d   = 1'b0;
                    bits_d  = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (t_q == '0) begin
                    state_d = ST_DONE;
                end else if (n_q <= N_W'(t_q)) begin
                    state_d = ST_FLUSH;
                end else begin
                    bd_n_d  = n_q;
                    bd_t_d  = t_q;
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // bd_d/bd_u are sampled on the edge ending the BD_LAT-th cycle
                // after bd_n/bd_t settle, so a full BD_LAT-register best_d fits.
                if (wait_q == WAIT_W'(BD_LAT)) begin
                    d_d     = bd_d;
                    u_d     = bd_u;
                    state_d = ST_RD_FLAG;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_RD_FLAG: begin
                if (fetch_fire) begin
                    bits_d = bits_q + 16'd1;
                    if (strm.bit_in) begin
                        if (N_W'(d_q) <= slack) begin
                            pos_d = pos_q + N_W'(d_q);
                            n_d   = n_q - N_W'(d_q);
                        end else begin
                            err_d = 1'b1;
                            pos_d = pos_q + slack;
                            n_d   = N_W'(t_q);
                        end
                        state_d = ST_CHECK;
                    end else begin
                        idx_d      = '0;
                        fetch_load = 1'b1;
                        state_d    = ST_RD_IDX;
                    end
                end
            end
            ST_RD_IDX: begin
                if (fetch_empty) begin
                    state_d = ST_EMIT;
                end else if (fetch_fire) begin
                    bits_d = bits_q + 16'd1;
                    if (fetch_last) begin
                        if (N_W'(fetch_value) > slack) begin
                            err_d = 1'b1;
                        end
                        idx_d   = D_W'(clamp_idx(N_W'(fetch_value), slack));
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (strm.pos_ready) begin
                    pos_d   = pos_q + N_W'(idx_q) + N_W'(1);
                    n_d     = n_q - N_W'(idx_q) - N_W'(1);
                    t_d     = t_q - T_W'(1);
                    state_d = ST_CHECK;
                end
            end
            ST_FLUSH: begin
                if (strm.pos_ready) begin
                    pos_d = pos_q + N_W'(1);
                    t_d   = t_q - T_W'(1);
                    if (t_q == T_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            t_q     <= '0;
            pos_q   <= '0;
            idx_q   <= '0;
            d_q     <= '0;
            u_q     <= '0;
            err_q   <= 1'b0;
            bits_q  <= '0;
            wait_q  <= '0;
            bd_n_q  <= '0;
            bd_t_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            t_q     <= t_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
            u_q     <= u_d;
            err_q   <= err_d;
            bits_q  <= bits_d;
            wait_q  <= wait_d;
            bd_n_q  <= bd_n_d;
            bd_t_q  <= bd_t_d;
        end
    end

endmodule
